prg_loader: RTL and testbench

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/prg_loader.sv | 176 +++++++++++++++++
 tb/tb_prg_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// prg_loader: serial program loader. Receives framed bytes from a UART
// receiver, writes the payload into target memory and holds the CPU in
// reset until a frame with a valid XOR checksum has been loaded.
module prg_loader #(
    parameter int          ADDR_W  = 14,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Idle-cycle counter only needs to reach TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_L, S_ADDR_H, S_LEN_L, S_LEN_H, S_DATA, S_CHK
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_s1_q, rdy_s2_q, rdy_h_q;
    logic                accept;
    logic [15:0]         ptr_q, ptr_d;   // full 16-bit start/write pointer; only low ADDR_W bits reach memory
    logic [15:0]         len_q, len_d;
    logic [7:0]          chk_q, chk_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                wren_q, wren_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                hold_q, hold_d;

    // Two-flop synchroniser plus history flop for the asynchronous byte strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_s1_q <= 1'b0;
            rdy_s2_q <= 1'b0;
            rdy_h_q  <= 1'b0;
        end else begin
            rdy_s1_q <= rx_ready;
            rdy_s2_q <= rdy_s1_q;
            rdy_h_q  <= rdy_s2_q;
        end
    end

    // A byte is taken on the synchronised rising edge; rx_byte is stable then.
    assign accept = rdy_s2_q & ~rdy_h_q;

    // State and datapath registers; everything clears on reset so a partial frame is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
        end
    end

    // Frame parser: next state, checksum, write strobe and idle timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        chk_d   = chk_q;
        tmo_d   = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        error_d = error_q;
        hold_d  = hold_q;

        if (state_q != S_IDLE && !accept) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == SYNC) begin
                        state_d = S_ADDR_L;
                        chk_d   = '0;
                        hold_d  = 1'b1;
                        error_d = 1'b0;
                    end
                end
                S_ADDR_L: begin
                    ptr_d[7:0] = rx_byte;
                    chk_d      = chk_q ^ rx_byte;
                    state_d    = S_ADDR_H;
                end
                S_ADDR_H: begin
                    ptr_d[15:8] = rx_byte;
                    chk_d       = chk_q ^ rx_byte;
                    state_d     = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d[7:0] = rx_byte;
                    chk_d      = chk_q ^ rx_byte;
                    state_d    = S_LEN_H;
                end
                S_LEN_H: begin
                    len_d[15:8] = rx_byte;
                    chk_d       = chk_q ^ rx_byte;
                    state_d     = ({rx_byte, len_q[7:0]} != 16'd0) ? S_DATA : S_CHK;
                end
                S_DATA: begin
                    addr_d  = ptr_q[ADDR_W-1:0];
                    data_d  = rx_byte;
                    wren_d  = 1'b1;
                    ptr_d   = ptr_q + 16'd1;
                    len_d   = len_q - 16'd1;
                    chk_d   = chk_q ^ rx_byte;
                    if (len_q == 16'd1) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (rx_byte == chk_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Abort a stalled frame; cpu_hold is deliberately left asserted.
        if (state_q != S_IDLE && !accept && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            tmo_d   = '0;
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_wren = wren_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = hold_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_prg_loader.sv
// tb_prg_loader: directed frames with a scoreboard of expected memory
// writes and done pulses, plus level checks on busy/cpu_hold/error.
module tb_prg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_done;
        logic [13:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    prg_loader #(
        .ADDR_W (14),
        .SYNC   (8'hA5),
        .TIMEOUT(100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_byte (rx_byte),
        .rx_ready(rx_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [13:0] a, input logic [7:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    // One byte: strobe high 4 clocks, low 4 clocks (well inside TIMEOUT).
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_byte = b;
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic check_levels(input string tag, input logic b, input logic h, input logic e);
        @(negedge clk);
        check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
        check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, h});
        check({tag, "_error"}, {31'b0, error}, {31'b0, e});
    endtask

    // Monitor: every write strobe or done pulse must match the next expected event.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_done) begin
                    total++; bad++;
                    $display("FAIL write_order: got write addr=%0h expected done pulse", mem_addr);
                end else begin
                    check("wr_addr", {18'b0, mem_addr}, {18'b0, mon_e.addr});
                    check("wr_data", {24'b0, mem_data}, {24'b0, mon_e.data});
                end
            end
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                mon_e = exp_q.pop_front();
                check("done_order", {31'b0, mon_e.is_done}, 32'd1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wren", {31'b0, mem_wren}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", {18'b0, mem_addr}, 32'd0);
        check("rst_data", {24'b0, mem_data}, 32'd0);
        check_levels("rst", 1'b0, 1'b0, 1'b0);

        // Non-SYNC bytes in IDLE are ignored, then SYNC starts a frame
        send_list('{8'h00, 8'hFF, 8'h5A});
        check_levels("idle_junk", 1'b0, 1'b0, 1'b0);
        send(8'hA5);
        check_levels("sync", 1'b1, 1'b1, 1'b0);

        // Good frame: 3 bytes at 0x100, checksum 00^01^03^00^11^22^33 = 02
        send_list('{8'h00, 8'h01, 8'h03, 8'h00});
        push_wr(14'h100, 8'h11);
        push_wr(14'h101, 8'h22);
        push_wr(14'h102, 8'h33);
        send_list('{8'h11, 8'h22, 8'h33});
        check_levels("good_pre_chk", 1'b1, 1'b1, 1'b0);
        push_done();
        send(8'h02);
        check_levels("good_end", 1'b0, 1'b0, 1'b0);

        // Bad checksum: writes still happen, error sticky, hold kept
        push_wr(14'h100, 8'h11);
        push_wr(14'h101, 8'h22);
        push_wr(14'h102, 8'h33);
        send_list('{8'hA5, 8'h00, 8'h01, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h04});
        check_levels("bad_chk", 1'b0, 1'b1, 1'b1);

        // New SYNC clears error; successful frame releases hold
        send(8'hA5);
        check_levels("resync", 1'b1, 1'b1, 1'b0);
        push_wr(14'h100, 8'h11);
        push_wr(14'h101, 8'h22);
        push_wr(14'h102, 8'h33);
        push_done();
        send_list('{8'h00, 8'h01, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h02});
        check_levels("recover", 1'b0, 1'b0, 1'b0);

        // Address wrap at 0x3FFF with an in-frame A5 payload byte; chk = 66
        push_wr(14'h3FFE, 8'h01);
        push_wr(14'h3FFF, 8'hA5);
        push_wr(14'h0000, 8'h03);
        push_wr(14'h0001, 8'h04);
        push_done();
        send_list('{8'hA5, 8'hFE, 8'h3F, 8'h04, 8'h00, 8'h01, 8'hA5, 8'h03, 8'h04, 8'h66});
        check_levels("wrap", 1'b0, 1'b0, 1'b0);

        // Timeout: stall after len lo, abort 100 idle cycles after last accept
        send_list('{8'hA5, 8'h00, 8'h01, 8'h03});
        repeat (85) @(posedge clk);
        check_levels("tmo_before", 1'b1, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        check_levels("tmo_after", 1'b0, 1'b1, 1'b1);

        // Zero-length frame: no writes, done; chk = 10
        push_done();
        send_list('{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10});
        check_levels("len0", 1'b0, 1'b0, 1'b0);

        // Reset mid-payload after 2 of 5 bytes
        push_wr(14'h200, 8'hD0);
        push_wr(14'h201, 8'hD1);
        send_list('{8'hA5, 8'h00, 8'h02, 8'h05, 8'h00, 8'hD0, 8'hD1});
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_wren", {31'b0, mem_wren}, 32'd0);
        check("mid_rst_addr", {18'b0, mem_addr}, 32'd0);
        check("mid_rst_data", {24'b0, mem_data}, 32'd0);
        check_levels("mid_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        send_list('{8'h33, 8'h44, 8'h55});
        check_levels("post_rst", 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("events_left", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
